// File: rtl/rename_alloc.sv
// rename_alloc: single-issue register-rename stage.
// Maps architectural rs1/rs2/rd to physical tags through a speculative RAT,
// pops one free-list entry per destination-writing instruction, and reports
// the displaced mapping so commit can recycle it. A committed RAT, written
// from the commit port, restores the speculative RAT on flush.
//
// Optional feature: define RENAME_STALL_STATS_EN to count free-list stall
// cycles on o_stall_cnt; when undefined the port is tied to zero.
module rename_alloc #(
  parameter int ARCH_W = 5,
  parameter int PREG_W = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ARCH_W-1:0] i_rs1,
  input  logic [ARCH_W-1:0] i_rs2,
  input  logic [ARCH_W-1:0] i_rd,
  input  logic              i_rd_en,
  input  logic              i_fl_empty,
  input  logic [PREG_W-1:0] i_fl_data,
  output logic              o_fl_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PREG_W-1:0] o_prs1,
  output logic [PREG_W-1:0] o_prs2,
  output logic [PREG_W-1:0] o_prd,
  output logic [PREG_W-1:0] o_old_prd,
  output logic              o_prd_en,
  input  logic              i_flush,
  input  logic              i_cmt_valid,
  input  logic [ARCH_W-1:0] i_cmt_rd,
  input  logic [PREG_W-1:0] i_cmt_prd,
  output logic [31:0]       o_stall_cnt
);

  localparam int NREG = 1 << ARCH_W;

  logic [PREG_W-1:0] spec_rat [NREG];
  logic [PREG_W-1:0] cmt_rat  [NREG];

  logic alloc;
  logic slot_free;
  logic accept;
  logic cmt_wr;

  // Handshake: x0 never allocates; an alloc waits on an empty free list.
  assign alloc     = i_rd_en & (i_rd != '0);
  assign slot_free = ~o_valid | i_ready;
  assign o_ready   = slot_free & ~i_flush & ~(alloc & i_fl_empty);
  assign accept    = i_valid & o_ready;
  assign o_fl_rd   = accept & alloc;
  assign cmt_wr    = i_cmt_valid & (i_cmt_rd != '0);

  // Committed RAT: architectural state as retired by the commit port.
  // NOTE: the RAT arrays are reset to identity, so they must be built from
  // flops rather than an inferred RAM; x0 entries are never written.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) cmt_rat[i] <= PREG_W'(i);
    end else if (cmt_wr) begin
      cmt_rat[i_cmt_rd] <= i_cmt_prd;
    end
  end

  // Speculative RAT: updated on allocation, restored from committed RAT on
  // flush with any same-cycle commit forwarded into the restore.
  // NOTE: all sequential state uses non-blocking assignments so every read
  // in this cycle sees the pre-edge table (no self-bypass of rd to sources).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) spec_rat[i] <= PREG_W'(i);
    end else if (i_flush) begin
      for (int i = 0; i < NREG; i++) begin
        if (cmt_wr && (i_cmt_rd == ARCH_W'(i))) spec_rat[i] <= i_cmt_prd;
        else                                    spec_rat[i] <= cmt_rat[i];
      end
    end else if (accept && alloc) begin
      spec_rat[i_rd] <= i_fl_data;
    end
  end

  // Output register: load on accept, drain when downstream takes it, hold
  // everything while stalled by downstream.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_prs1    <= '0;
      o_prs2    <= '0;
      o_prd     <= '0;
      o_old_prd <= '0;
      o_prd_en  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid   <= 1'b1;
      o_prs1    <= spec_rat[i_rs1];
      o_prs2    <= spec_rat[i_rs2];
      o_prd     <= alloc ? i_fl_data : '0;
      o_old_prd <= alloc ? spec_rat[i_rd] : '0;
      o_prd_en  <= alloc;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef RENAME_STALL_STATS_EN
  logic [31:0] stall_cnt;

  // Count cycles where a ready slot is lost only to an empty free list.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt <= '0;
    end else if (i_valid && alloc && i_fl_empty && slot_free && !i_flush) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rename_alloc.sv
// Directed testbench for rename_alloc. Inputs change 1 time unit after the
// rising edge; registered outputs are sampled there before new stimulus,
// combinational outputs 1 unit after the stimulus settles.
module tb_rename_alloc;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rs1, i_rs2, i_rd;
  logic        i_rd_en;
  logic        i_fl_empty;
  logic [5:0]  i_fl_data;
  logic        o_fl_rd;
  logic        o_valid;
  logic        i_ready;
  logic [5:0]  o_prs1, o_prs2, o_prd, o_old_prd;
  logic        o_prd_en;
  logic        i_flush;
  logic        i_cmt_valid;
  logic [4:0]  i_cmt_rd;
  logic [5:0]  i_cmt_prd;
  logic [31:0] o_stall_cnt;

  int total = 0;
  int bad   = 0;

`ifdef RENAME_STALL_STATS_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  rename_alloc #(.ARCH_W(5), .PREG_W(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rd_en(i_rd_en),
    .i_fl_empty(i_fl_empty), .i_fl_data(i_fl_data), .o_fl_rd(o_fl_rd),
    .o_valid(o_valid), .i_ready(i_ready), .o_prs1(o_prs1), .o_prs2(o_prs2),
    .o_prd(o_prd), .o_old_prd(o_old_prd), .o_prd_en(o_prd_en),
    .i_flush(i_flush), .i_cmt_valid(i_cmt_valid), .i_cmt_rd(i_cmt_rd),
    .i_cmt_prd(i_cmt_prd), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Packed view of the registered output bundle.
  wire [25:0] out_vec = {o_valid, o_prs1, o_prs2, o_prd, o_old_prd, o_prd_en};
  // Packed view of the combinational handshake outputs.
  wire [1:0]  hs_vec  = {o_ready, o_fl_rd};

  function automatic logic [25:0] ov(input bit v, input int p1, input int p2,
                                     input int pd, input int po, input bit en);
    return {v, 6'(p1), 6'(p2), 6'(pd), 6'(po), en};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    i_valid = 1'b0; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_rd_en = 1'b0;
    i_fl_empty = 1'b0; i_fl_data = '0; i_ready = 1'b1; i_flush = 1'b0;
    i_cmt_valid = 1'b0; i_cmt_rd = '0; i_cmt_prd = '0;
  endtask

  task automatic drive_instr(input int rs1, input int rs2, input int rd,
                             input bit rd_en, input int fl);
    i_valid = 1'b1; i_rs1 = 5'(rs1); i_rs2 = 5'(rs2); i_rd = 5'(rd);
    i_rd_en = rd_en; i_fl_data = 6'(fl);
  endtask

  task automatic test_reset();
    drive_idle();
    i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    total++;
    if (out_vec !== ov(0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_out got=%h exp=%h", out_vec, ov(0, 0, 0, 0, 0, 0));
    end
    total++;
    if (hs_vec !== 2'b10) begin
      bad++; $display("FAIL reset_handshake got=%b exp=%b", hs_vec, 2'b10);
    end
    total++;
    if (o_stall_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_stall got=%0d exp=0", o_stall_cnt);
    end
  endtask

  task automatic test_basic();
    drive_instr(3, 5, 7, 1, 33);
    #1;
    total++;
    if (hs_vec !== 2'b11) begin
      bad++; $display("FAIL basic_pop got=%b exp=%b", hs_vec, 2'b11);
    end
    tick();
    total++;
    if (out_vec !== ov(1, 3, 5, 33, 7, 1)) begin
      bad++; $display("FAIL basic_out got=%h exp=%h", out_vec, ov(1, 3, 5, 33, 7, 1));
    end
  endtask

  // Continues straight from test_basic: RAT[7]=33 is visible immediately.
  task automatic test_back_to_back();
    drive_instr(7, 0, 7, 1, 35);
    #1;
    total++;
    if (o_fl_rd !== 1'b1) begin
      bad++; $display("FAIL b2b_pop got=%b exp=1", o_fl_rd);
    end
    tick();
    total++;
    if (out_vec !== ov(1, 33, 0, 35, 33, 1)) begin
      bad++; $display("FAIL b2b_out1 got=%h exp=%h", out_vec, ov(1, 33, 0, 35, 33, 1));
    end
    drive_instr(7, 3, 9, 1, 36);
    tick();
    total++;
    if (out_vec !== ov(1, 35, 3, 36, 9, 1)) begin
      bad++; $display("FAIL b2b_out2 got=%h exp=%h", out_vec, ov(1, 35, 3, 36, 9, 1));
    end
    drive_idle();
    tick();
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got=%b exp=0", o_valid);
    end
  endtask

  // Spec RAT now: 7->35, 9->36.
  task automatic test_x0();
    drive_instr(0, 9, 0, 1, 50);
    #1;
    total++;
    if (hs_vec !== 2'b10) begin
      bad++; $display("FAIL x0_nopop got=%b exp=%b", hs_vec, 2'b10);
    end
    tick();
    total++;
    if (out_vec !== ov(1, 0, 36, 0, 0, 0)) begin
      bad++; $display("FAIL x0_out got=%h exp=%h", out_vec, ov(1, 0, 36, 0, 0, 0));
    end
    drive_instr(0, 7, 0, 0, 51);
    tick();
    total++;
    if (out_vec !== ov(1, 0, 35, 0, 0, 0)) begin
      bad++; $display("FAIL x0_src got=%h exp=%h", out_vec, ov(1, 0, 35, 0, 0, 0));
    end
    drive_idle();
    tick();
  endtask

  task automatic test_fl_empty();
    drive_instr(1, 1, 10, 1, 60);
    i_fl_empty = 1'b1;
    #1;
    total++;
    if (hs_vec !== 2'b00) begin
      bad++; $display("FAIL empty_block got=%b exp=%b", hs_vec, 2'b00);
    end
    tick(); tick(); tick();
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL empty_noissue got=%b exp=0", o_valid);
    end
    total++;
    if (o_stall_cnt !== (STALL_ON ? 32'd3 : 32'd0)) begin
      bad++; $display("FAIL empty_stall got=%0d exp=%0d", o_stall_cnt, STALL_ON ? 3 : 0);
    end
    drive_instr(9, 2, 10, 0, 60);
    #1;
    total++;
    if (hs_vec !== 2'b10) begin
      bad++; $display("FAIL empty_nonalloc_hs got=%b exp=%b", hs_vec, 2'b10);
    end
    tick();
    total++;
    if (out_vec !== ov(1, 36, 2, 0, 0, 0)) begin
      bad++; $display("FAIL empty_nonalloc got=%h exp=%h", out_vec, ov(1, 36, 2, 0, 0, 0));
    end
    total++;
    if (o_stall_cnt !== (STALL_ON ? 32'd3 : 32'd0)) begin
      bad++; $display("FAIL empty_stall_hold got=%0d exp=%0d", o_stall_cnt, STALL_ON ? 3 : 0);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_backpressure();
    drive_instr(7, 9, 11, 1, 40);
    i_ready = 1'b0;
    tick();
    total++;
    if (out_vec !== ov(1, 35, 36, 40, 11, 1)) begin
      bad++; $display("FAIL bp_first got=%h exp=%h", out_vec, ov(1, 35, 36, 40, 11, 1));
    end
    drive_instr(11, 0, 12, 1, 41);
    i_ready = 1'b0;
    #1;
    total++;
    if (hs_vec !== 2'b00) begin
      bad++; $display("FAIL bp_block got=%b exp=%b", hs_vec, 2'b00);
    end
    tick(); tick();
    total++;
    if (out_vec !== ov(1, 35, 36, 40, 11, 1)) begin
      bad++; $display("FAIL bp_hold got=%h exp=%h", out_vec, ov(1, 35, 36, 40, 11, 1));
    end
    i_ready = 1'b1;
    #1;
    total++;
    if (hs_vec !== 2'b11) begin
      bad++; $display("FAIL bp_release got=%b exp=%b", hs_vec, 2'b11);
    end
    tick();
    total++;
    if (out_vec !== ov(1, 40, 0, 41, 12, 1)) begin
      bad++; $display("FAIL bp_next got=%h exp=%h", out_vec, ov(1, 40, 0, 41, 12, 1));
    end
    drive_idle();
    tick();
  endtask

  // Spec RAT: 7->35, 9->36, 11->40, 12->41; committed RAT still identity.
  task automatic test_flush();
    drive_instr(0, 0, 7, 1, 33);
    tick();
    total++;
    if (out_vec !== ov(1, 0, 0, 33, 35, 1)) begin
      bad++; $display("FAIL flush_pre got=%h exp=%h", out_vec, ov(1, 0, 0, 33, 35, 1));
    end
    drive_instr(7, 7, 13, 1, 42);
    i_flush = 1'b1; i_cmt_valid = 1'b1; i_cmt_rd = 5'd7; i_cmt_prd = 6'd41;
    #1;
    total++;
    if (hs_vec !== 2'b00) begin
      bad++; $display("FAIL flush_block got=%b exp=%b", hs_vec, 2'b00);
    end
    tick();
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL flush_kill got=%b exp=0", o_valid);
    end
    drive_idle();
    drive_instr(7, 11, 0, 0, 0);
    tick();
    total++;
    if (out_vec !== ov(1, 41, 11, 0, 0, 0)) begin
      bad++; $display("FAIL flush_restore got=%h exp=%h", out_vec, ov(1, 41, 11, 0, 0, 0));
    end
    // Commit to x0 alongside a flush must leave x0 at phys 0.
    drive_idle();
    i_flush = 1'b1; i_cmt_valid = 1'b1; i_cmt_rd = 5'd0; i_cmt_prd = 6'd20;
    tick();
    drive_idle();
    drive_instr(0, 7, 0, 0, 0);
    tick();
    total++;
    if (out_vec !== ov(1, 0, 41, 0, 0, 0)) begin
      bad++; $display("FAIL flush_x0 got=%h exp=%h", out_vec, ov(1, 0, 41, 0, 0, 0));
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive_instr(1, 2, 7, 1, 50);
    tick();
    drive_instr(3, 4, 8, 1, 51);
    i_reset = 1'b1;
    i_flush = 1'b1; i_cmt_valid = 1'b1; i_cmt_rd = 5'd7; i_cmt_prd = 6'd55;
    tick();
    i_reset = 1'b0;
    drive_idle();
    total++;
    if (out_vec !== ov(0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL midreset_out got=%h exp=%h", out_vec, ov(0, 0, 0, 0, 0, 0));
    end
    drive_instr(7, 8, 0, 0, 0);
    tick();
    total++;
    if (out_vec !== ov(1, 7, 8, 0, 0, 0)) begin
      bad++; $display("FAIL midreset_identity got=%h exp=%h", out_vec, ov(1, 7, 8, 0, 0, 0));
    end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_x0();
    test_fl_empty();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_alloc.md
Name: rename_alloc

Overview:
Single-issue register-rename stage directly upstream of the odd-bank physical-register free list.
- Translates architectural rs1/rs2/rd to physical tags through a speculative register alias table (RAT).
- Pops one free physical register per instruction that writes a destination.
- Reports the previous mapping (old_prd) so commit can later push it back to the free list.
- Keeps a committed RAT, driven from the commit port, which restores the speculative RAT on flush.

Parameters:
- ARCH_W, 5, architectural register index width; 2^ARCH_W architectural registers.
- PREG_W, 6, physical register tag width; must match free-list data width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage accepts instruction this cycle
- i_rs1  in  ARCH_W  source 1 architectural index
- i_rs2  in  ARCH_W  source 2 architectural index
- i_rd  in  ARCH_W  destination architectural index
- i_rd_en  in  1  instruction writes rd
- i_fl_empty  in  1  free list empty
- i_fl_data  in  PREG_W  free-list head (combinational read data)
- o_fl_rd  out  1  pop free-list head
- o_valid  out  1  renamed instruction valid
- i_ready  in  1  downstream accepts
- o_prs1  out  PREG_W  renamed source 1
- o_prs2  out  PREG_W  renamed source 2
- o_prd  out  PREG_W  allocated destination (0 if no alloc)
- o_old_prd  out  PREG_W  previous mapping of rd (0 if no alloc)
- o_prd_en  out  1  destination allocated
- i_flush  in  1  squash speculative state
- i_cmt_valid  in  1  commit of a destination-writing instruction
- i_cmt_rd  in  ARCH_W  committed architectural rd
- i_cmt_prd  in  PREG_W  committed physical rd
- o_stall_cnt  out  32  free-list stall cycle count (see Optional Feature)

Behaviour:
- Reset (i_reset=1, highest priority):
  - Both RATs set to identity: arch r maps to phys r.
  - o_valid=0, all output data fields 0, o_fl_rd=0, o_stall_cnt=0.
- alloc = i_rd_en & (i_rd != 0). Writes to x0 never allocate; x0 always maps to phys 0.
- slot_free = ~o_valid | i_ready.
- o_ready = slot_free & ~i_flush & ~(alloc & i_fl_empty). Combinational; no dependence on i_valid.
- Accept = i_valid & o_ready. On accept, at the next edge:
  - o_prs1/o_prs2 take the speculative-RAT entries read before this cycle's update; an instruction's own rd never bypasses to its sources.
  - If alloc: o_prd=i_fl_data, o_old_prd=RAT[i_rd], o_prd_en=1, RAT[i_rd]<=i_fl_data.
  - If not alloc: o_prd=0, o_old_prd=0, o_prd_en=0.
  - o_valid<=1.
- o_fl_rd = accept & alloc. Combinational, same cycle as accept; never asserted while i_fl_empty.
- No accept and i_ready=1: o_valid<=0. While o_valid & ~i_ready, all outputs hold stable.
- Back-to-back dependency: instruction N+1 reads the RAT after N's update, so it sees N's prd. Latency 1 cycle, throughput 1 per cycle.
- Commit: when i_cmt_valid, committed RAT[i_cmt_rd]<=i_cmt_prd. Writes with i_cmt_rd==0 are ignored.
- Flush (i_flush=1):
  - o_valid<=0; no accept; o_fl_rd=0.
  - Speculative RAT <= committed RAT, including any same-cycle commit write (commit forwarded into the restore).
  - Flush overrides a concurrent i_ready.
- Reset mid-operation discards the in-flight output and any pending flush/commit.

Optional Feature:
- Macro RENAME_STALL_STATS_EN.
- Defined: o_stall_cnt increments by 1, wrapping at 2^32, every cycle with i_valid & alloc & i_fl_empty & slot_free & ~i_flush. Cleared by reset.
- Undefined: o_stall_cnt tied to 0; no counter logic.

Test Plan:
- After reset, rs1=3, rs2=5, rd=7, rd_en=1, fl_data=33 -> o_fl_rd=1 same cycle; next cycle o_prs1=3, o_prs2=5, o_prd=33, o_old_prd=7, o_prd_en=1.
- Back-to-back: rd=7 gets 33, then rs1=7, rd=7 with fl_data=35 -> second output o_prs1=33, o_prd=35, o_old_prd=33.
- rd_en=1, rd=0 -> no pop, o_prd_en=0, o_prd=0; a later rs1=0 still yields 0.
- i_fl_empty=1 with alloc -> o_ready=0, no pop, o_stall_cnt increments each cycle (macro on); a non-alloc instruction is still accepted.
- i_ready=0 with o_valid=1 -> outputs hold, o_ready=0; releasing i_ready lets the next instruction issue in the following cycle.
- Rename rd=7->33, commit (7,41) in the same cycle as i_flush -> next cycle o_valid=0; a subsequent rs1=7 renames to 41.
